// File: rtl/fft_frame_loader_if.sv
// Purpose: sample-stream and FFT-core load signals shared by the loader and its environment.
// Latency: none, wiring only.
// Backpressure: none here; the core paces loading with rfd/xn_index, samples are never stalled.
interface fft_frame_loader_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          rfd;
  logic [AW-1:0] xn_index;
  logic          done;
  logic          start;
  logic [DW-1:0] xn_re;
  logic [DW-1:0] xn_im;
  logic          fwd_inv;
  logic          fwd_inv_we;

  // Environment side: audio source plus FFT core.
  modport master (
    output sample_in, sample_valid, rfd, xn_index, done,
    input  start, xn_re, xn_im, fwd_inv, fwd_inv_we
  );

  // Loader side.
  modport slave (
    input  sample_in, sample_valid, rfd, xn_index, done,
    output start, xn_re, xn_im, fwd_inv, fwd_inv_we
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Purpose: ping-pong frame buffer that collects audio samples and feeds whole frames to an FFT core.
// Latency: start 2 cycles after the frame's last write; xn_re 1 cycle after rfd/xn_index.
// Backpressure: none on samples; one finished frame may wait, a frame finishing behind it is dropped.
module fft_frame_loader #(
  parameter int N_POINTS = 1024,
  parameter int AW       = 10,
  parameter int DW       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_frame_loader_if.slave  bus,
  output logic               overflow,
  output logic [7:0]         drop_count
);

  typedef enum logic [2:0] {CFG, IDLE, START, LOAD, WAIT_DONE} state_t;

  state_t        state;
  logic [DW-1:0] bank [2][N_POINTS];
  logic [AW-1:0] wr_ptr;
  logic          fill_sel;     // bank index currently being filled; the other is the load bank
  logic          fill_full;    // fill bank holds a complete frame not yet handed to the core
  logic          skip_frame;   // current incoming frame began while the fill bank was occupied
  logic          rfd_seen;
  logic [DW-1:0] xn_re_q;
  logic          start_q;
  logic          fwd_inv_q;
  logic          fwd_inv_we_q;

  logic          swap_now;
  logic          wr_first;
  logic          wr_last;
  logic          skip_eff;
  logic          wr_bank;

  // A waiting frame is handed over whenever the load side is idle.
  assign swap_now = (state == IDLE) && fill_full;
  assign wr_first = (wr_ptr == '0);
  assign wr_last  = (wr_ptr == AW'(N_POINTS - 1));
  // Fate of a frame is decided at its first sample: it is kept only if the fill bank will be free.
  assign skip_eff = wr_first ? (fill_full && !swap_now) : skip_frame;
  // A write landing on the swap edge belongs to the bank that becomes the new fill bank.
  assign wr_bank  = swap_now ? ~fill_sel : fill_sel;

  assign bus.start      = start_q;
  assign bus.xn_re      = xn_re_q;
  assign bus.xn_im      = '0;
  assign bus.fwd_inv    = fwd_inv_q;
  assign bus.fwd_inv_we = fwd_inv_we_q;

  // Sample storage: plain write port, contents need no reset.
  always_ff @(posedge clk) begin
    if (bus.sample_valid && !skip_eff) begin
      bank[wr_bank][wr_ptr] <= bus.sample_in;
    end
  end

  // Fill side: write pointer, bank ownership, frame completion and drop accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill_sel   <= 1'b0;
      fill_full  <= 1'b0;
      skip_frame <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (swap_now) begin
        fill_sel  <= ~fill_sel;
        fill_full <= 1'b0;
      end
      if (bus.sample_valid) begin
        wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        if (wr_first) begin
          skip_frame <= skip_eff;
        end
        if (wr_last) begin
          if (skip_eff) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
              drop_count <= drop_count + 8'd1;
            end
          end else begin
            fill_full <= 1'b1;
          end
        end
      end
    end
  end

  // Load side FSM: configure direction once, then start/load/wait per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CFG;
      start_q      <= 1'b0;
      xn_re_q      <= '0;
      fwd_inv_q    <= 1'b1;
      fwd_inv_we_q <= 1'b0;
      rfd_seen     <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      fwd_inv_we_q <= 1'b0;
      case (state)
        CFG: begin
          fwd_inv_q    <= 1'b1;
          fwd_inv_we_q <= 1'b1;
          state        <= IDLE;
        end
        IDLE: begin
          if (swap_now) begin
            start_q <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          rfd_seen <= 1'b0;
          state    <= LOAD;
        end
        LOAD: begin
          if (bus.rfd) begin
            rfd_seen <= 1'b1;
            xn_re_q  <= bank[~fill_sel][bus.xn_index];
          end else if (rfd_seen) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Returning to IDLE frees the load bank for the next swap.
          if (bus.done) begin
            state <= IDLE;
          end
        end
        default: state <= CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Purpose: directed-sequence bench with random frame data and a frame-queue reference model.
// Latency: checks start timing relative to the last write or done, and xn_re one cycle after rfd.
// Backpressure: exercises a waiting frame, a dropped frame and done coinciding with frame completion.
module tb_fft_frame_loader;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic overflow;
  logic [7:0] drop_count;

  fft_frame_loader_if #(.AW(AW), .DW(DW)) bus ();

  fft_frame_loader #(.N_POINTS(N), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Frame data: 0 = index, 1 = 1000+i, others random.
  logic [DW-1:0] frames [7][N];

  // Reference model: at most one finished frame may wait for the core; any frame finishing
  // while one is already waiting is lost and counted.
  int ready_q[$];
  int model_drops = 0;
  logic model_ovf = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_starts = 0;

  // Event monitor, sampled mid-cycle.
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int we_cnt = 0;

  // Cycle index advances on each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record start pulses, writes, done pulses and direction strobes.
  always @(negedge clk) begin
    if (bus.start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (bus.sample_valid === 1'b1) last_wr_cyc <= cyc;
    if (bus.done === 1'b1) done_cyc <= cyc;
    if (bus.fwd_inv_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_frame_written(input int id);
    if (ready_q.size() != 0) begin
      if (model_drops < 255) model_drops++;
      model_ovf = 1'b1;
    end else begin
      ready_q.push_back(id);
    end
  endtask

  task automatic write_frame(input int id, input bit done_last);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(7) == 0) begin
        bus.sample_valid = 1'b0;
        tick();
      end
      bus.sample_valid = 1'b1;
      bus.sample_in    = frames[id][i];
      if (done_last) bus.done = (i == N - 1);
      tick();
    end
    bus.sample_valid = 1'b0;
    bus.sample_in    = DW'($urandom);
    if (done_last) bus.done = 1'b0;
    model_frame_written(id);
  endtask

  task automatic expect_start(input string tag, input int ref_cyc, output int id);
    exp_starts++;
    for (int b = 0; b < 40 && start_cnt < exp_starts; b++) tick();
    check({tag, "_start_seen"}, start_cnt, exp_starts);
    check({tag, "_start_latency"}, start_cyc - ref_cyc, 2);
    id = 0;
    if (ready_q.size() != 0) id = ready_q.pop_front();
  endtask

  task automatic load_frame(input string tag, input int id, input int n, input bit finish,
                            input int done_at);
    int bad_re;
    int bad_im;
    bad_re = 0;
    bad_im = 0;
    for (int i = 0; i < n; i++) begin
      bus.rfd      = 1'b1;
      bus.xn_index = AW'(i);
      if (done_at >= 0) bus.done = (i == done_at);
      tick();
      if (bus.xn_re !== frames[id][i]) bad_re++;
      if (bus.xn_im !== '0) bad_im++;
    end
    if (done_at >= 0) bus.done = 1'b0;
    check({tag, "_xn_re_errors"}, bad_re, 0);
    check({tag, "_xn_im_errors"}, bad_im, 0);
    if (finish) begin
      bus.rfd      = 1'b0;
      bus.xn_index = AW'($urandom);
      repeat (4) tick();
      check({tag, "_xn_re_hold"}, bus.xn_re, frames[id][n-1]);
    end
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, bus.start, 0);
    check({tag, "_xn_re"}, bus.xn_re, 0);
    check({tag, "_xn_im"}, bus.xn_im, 0);
    check({tag, "_fwd_inv"}, bus.fwd_inv, 1);
    check({tag, "_fwd_inv_we"}, bus.fwd_inv_we, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int id;
    int we_before;

    for (int f = 0; f < 7; f++) begin
      for (int i = 0; i < N; i++) begin
        if (f == 0)      frames[f][i] = DW'(i);
        else if (f == 1) frames[f][i] = DW'(1000 + i);
        else             frames[f][i] = DW'($urandom);
      end
    end

    rst_n            = 1'b0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.rfd          = 1'b0;
    bus.xn_index     = '0;
    bus.done         = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Release: one direction write, no start.
    rst_n = 1'b1;
    tick();
    check("cfg_fwd_inv_we", bus.fwd_inv_we, 1);
    check("cfg_fwd_inv", bus.fwd_inv, 1);
    repeat (5) tick();
    check("cfg_we_cycles", we_cnt, 1);
    check("cfg_no_start", start_cnt, 0);

    // Frame A (value = index); frame B (1000+i) written while A loads; done mid-load ignored.
    write_frame(0, 1'b0);
    expect_start("frame_a", last_wr_cyc, id);
    fork
      write_frame(1, 1'b0);
      load_frame("frame_a", id, N, 1'b1, 300);
    join
    repeat (3) tick();
    check("busy_no_extra_start", start_cnt, exp_starts);
    check("busy_overflow", overflow, model_ovf);

    pulse_done();
    expect_start("frame_b", done_cyc, id);
    load_frame("frame_b", id, N, 1'b1, -1);

    // Frame E completes on the same cycle as done: swap follows, no drop.
    write_frame(2, 1'b1);
    expect_start("frame_e", last_wr_cyc, id);
    check("coincide_overflow", overflow, model_ovf);
    check("coincide_drop_count", drop_count, model_drops);
    load_frame("frame_e", id, N, 1'b1, -1);

    // Frames C and D with done withheld: D is dropped, C survives.
    write_frame(3, 1'b0);
    write_frame(4, 1'b0);
    repeat (5) tick();
    check("drop_no_start", start_cnt, exp_starts);
    check("drop_overflow", overflow, model_ovf);
    check("drop_count", drop_count, model_drops);
    pulse_done();
    expect_start("frame_c", done_cyc, id);
    load_frame("frame_c", id, N, 1'b1, -1);
    check("after_c_drop_count", drop_count, model_drops);

    // Frame F, reset mid-load at index 500.
    pulse_done();
    write_frame(5, 1'b0);
    expect_start("frame_f", last_wr_cyc, id);
    load_frame("frame_f_part", id, 501, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    bus.rfd = 1'b0;
    repeat (2) tick();
    ready_q.delete();
    model_drops = 0;
    model_ovf   = 1'b0;
    we_before   = we_cnt;
    rst_n = 1'b1;
    tick();
    check("rerelease_fwd_inv_we", bus.fwd_inv_we, 1);
    repeat (8) tick();
    check("rerelease_we_cycles", we_cnt - we_before, 1);
    check("rerelease_no_start", start_cnt, exp_starts);

    // Fresh full frame after reset is issued normally.
    write_frame(6, 1'b0);
    expect_start("frame_g", last_wr_cyc, id);
    load_frame("frame_g", id, N, 1'b1, -1);
    check("final_overflow", overflow, model_ovf);
    check("final_drop_count", drop_count, model_drops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
